// File: rtl/handshake_bus_receiver.sv
// Toggle-handshake bus receiver: settle after each request edge, capture, offer on valid/ready.
// Latency: out_valid rises SETTLE_CYCLES+2 cycles after the request edge; ack toggles 1 cycle after accept.
// Backpressure: word is held and ack withheld until out_ready, so the sender stalls end-to-end.
module handshake_bus_receiver #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_sync,
    input  logic [WIDTH-1:0] data_sync,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ack_toggle,
    output logic             proto_err
);

    localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t           state_q;
    logic             req_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             ack_q;
    logic             err_q;
    logic             req_edge;

    assign req_edge = req_sync ^ req_prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            req_prev_q <= 1'b0;
            cnt_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            req_prev_q <= req_sync;
            // An edge outside IDLE means the sender did not wait for our ack.
            if (req_edge && (state_q != IDLE)) begin
                err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (req_edge) begin
                        cnt_q   <= SETTLE_LOAD;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        data_q  <= data_sync;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        ack_q   <= ~ack_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign ack_toggle = ack_q;
    assign proto_err  = err_q;

endmodule
